// File: rtl/iq_unpack_if.sv
// ============================================================================
// Module   : iq_unpack_if
// Brief    : Byte-FIFO read port plus I and Q FIFO write ports of iq_unpack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iq_unpack_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] i_out;
  logic                  i_wr_en;
  logic                  i_full;
  logic [DATA_WIDTH-1:0] q_out;
  logic                  q_wr_en;
  logic                  q_full;

  modport master (
    input  in_dout, in_empty, i_full, q_full,
    output in_rd_en, i_out, i_wr_en, q_out, q_wr_en
  );

  modport slave (
    output in_dout, in_empty, i_full, q_full,
    input  in_rd_en, i_out, i_wr_en, q_out, q_wr_en
  );
endinterface

`default_nettype wire

// File: rtl/iq_unpack.sv
// ============================================================================
// Module   : iq_unpack
// Brief    : Assembles little-endian bytes into dequantized I/Q sample pairs.
//            Optional macro IQ_UNPACK_COUNT_EN adds a 32-bit sample_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_unpack #(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10,
  parameter int BYTE_WIDTH = 8
) (
  input  wire logic    clock,
  input  wire logic    reset,
  iq_unpack_if.master  bus
`ifdef IQ_UNPACK_COUNT_EN
  ,
  output logic [31:0]  sample_count
`endif
);

  typedef enum logic [0:0] {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [1:0]              r_byte_cnt;
  logic [BYTE_WIDTH-1:0]   r_byte0;
  logic [BYTE_WIDTH-1:0]   r_byte1;
  logic [BYTE_WIDTH-1:0]   r_byte2;
  logic [DATA_WIDTH-1:0]   r_i_out;
  logic [DATA_WIDTH-1:0]   r_q_out;
  logic                    w_pop;
  logic                    w_wr;

  logic signed [2*BYTE_WIDTH-1:0] w_i_raw;
  logic signed [2*BYTE_WIDTH-1:0] w_q_raw;
  logic [DATA_WIDTH-1:0]          w_i_deq;
  logic [DATA_WIDTH-1:0]          w_q_deq;

  // The Q high byte is taken straight from the FIFO head on the final pop.
  assign w_i_raw = {r_byte1, r_byte0};
  assign w_q_raw = {bus.in_dout, r_byte2};
  assign w_i_deq = DATA_WIDTH'(w_i_raw) << QUANT_BITS;
  assign w_q_deq = DATA_WIDTH'(w_q_raw) << QUANT_BITS;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      S_READ: begin
        w_pop = reset && !bus.in_empty;
        if (w_pop && (r_byte_cnt == 2'd3)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr = reset && !bus.i_full && !bus.q_full;
        if (w_wr) begin
          w_state_next = S_READ;
        end
      end
      default: w_state_next = S_READ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_READ;
      r_byte_cnt <= 2'd0;
      r_byte0    <= '0;
      r_byte1    <= '0;
      r_byte2    <= '0;
      r_i_out    <= '0;
      r_q_out    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_byte0 <= bus.in_dout;
          2'd1: r_byte1 <= bus.in_dout;
          2'd2: r_byte2 <= bus.in_dout;
          default: begin
            r_i_out <= w_i_deq;
            r_q_out <= w_q_deq;
          end
        endcase
      end
    end
  end

  assign bus.in_rd_en = w_pop;
  assign bus.i_wr_en  = w_wr;
  assign bus.q_wr_en  = w_wr;
  assign bus.i_out    = r_i_out;
  assign bus.q_out    = r_q_out;

`ifdef IQ_UNPACK_COUNT_EN
  logic [31:0] r_sample_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sample_count <= 32'd0;
    end else if (w_wr) begin
      r_sample_count <= r_sample_count + 32'd1;
    end
  end

  assign sample_count = r_sample_count;
`endif

endmodule

`default_nettype wire
